// File: rtl/wide_add_pkg.sv
// Shared constants and helpers for the slice-serial wide adder.
package wide_add_pkg;

  localparam int unsigned SLICE_W = 16;

  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StRun  = 2'd1;
  localparam state_t StDone = 2'd2;

  // Slice index width; never below one bit so NUM_WORDS=1 still has a counter.
  function automatic int unsigned idx_width(int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adder_16bit.sv
// 16-bit ripple-carry adder stage with carry-in and carry-out.
module adder_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        Cin,
  output logic [15:0] y,
  output logic        Co
);

  always_comb begin : ripple
    logic c;
    c = Cin;
    y = '0;
    for (int i = 0; i < 16; i++) begin
      y[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
    end
    Co = c;
  end

endmodule

// File: rtl/wide_add_seq.sv
// Multi-cycle wide add/subtract: one 16-bit slice per cycle through a single adder_16bit,
// LSB slice first, carry chained through a register.
module wide_add_seq
  import wide_add_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [SLICE_W*NUM_WORDS-1:0]   a,
  input  logic [SLICE_W*NUM_WORDS-1:0]   b,
  input  logic                           cin,
  input  logic                           sub,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [SLICE_W*NUM_WORDS-1:0]   sum,
  output logic                           cout,
  output logic                           ovf
);

  localparam int unsigned W    = SLICE_W * NUM_WORDS;
  localparam int unsigned IdxW = idx_width(NUM_WORDS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_WORDS - 1);

  state_t            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d;
  logic [W-1:0]      op_a_q, op_a_d;
  logic [W-1:0]      op_b_q, op_b_d;
  logic [W-1:0]      sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;

  logic [SLICE_W-1:0] slice_a, slice_b, slice_y;
  logic               slice_co;

  assign slice_a = op_a_q[SLICE_W*32'(idx_q) +: SLICE_W];
  assign slice_b = op_b_q[SLICE_W*32'(idx_q) +: SLICE_W];

  adder_16bit u_adder (
    .a   (slice_a),
    .b   (slice_b),
    .Cin (carry_q),
    .y   (slice_y),
    .Co  (slice_co)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          op_a_d  = a;
          op_b_d  = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d[SLICE_W*32'(idx_q) +: SLICE_W] = slice_y;
        carry_d = slice_co;
        if (idx_q == LastIdx) begin
          cout_d  = slice_co;
          // Carry into the MSB xor carry out of it.
          ovf_d   = op_a_q[W-1] ^ op_b_q[W-1] ^ slice_y[SLICE_W-1] ^ slice_co;
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      carry_q <= 1'b0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_wide_add_seq.sv
// Scoreboard bench for wide_add_seq: accepted operands push a modelled result, a monitor
// pops and checks it (value, latency, stability) whenever out_valid is presented.
module tb_wide_add_seq;

  localparam int NW = 4;
  localparam int W  = 16 * NW;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         cin, sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout, ovf;

  always #5 clk = ~clk;

  wide_add_seq #(.NUM_WORDS(NW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           acc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   ncyc   = 0;
  int   ready_mode = 1;  // 0 random, 1 held low, 2 held high

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  // Reference: full-width modular sum plus a signed range test for overflow.
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mcin, input logic msub, input int acc);
    exp_t r;
    logic [W-1:0]          bp;
    logic                  c;
    logic [W:0]            u;
    logic signed [W+1:0]   s;
    bp = msub ? ~mb : mb;
    c  = msub ? 1'b1 : mcin;
    u  = {1'b0, ma} + {1'b0, bp} + {{W{1'b0}}, c};
    s  = $signed({ma[W-1], ma[W-1], ma}) + $signed({bp[W-1], bp[W-1], bp})
       + $signed({{(W+1){1'b0}}, c});
    r.sum  = u[W-1:0];
    r.cout = u[W];
    r.ovf  = (s[W+1:W-1] != 3'b000) && (s[W+1:W-1] != 3'b111);
    r.acc  = acc;
    return r;
  endfunction

  // out_ready driver, updated just after each rising edge.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       out_ready = ($urandom_range(0, 2) != 0);
        1:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor / scoreboard.
  initial begin
    exp_t cur;
    bit   have_cur;
    have_cur = 0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (rst) begin
        exp_q.delete();
        have_cur = 0;
      end else begin
        if (out_valid) begin
          chk("in_ready_in_done", W'(in_ready), W'(0));
          if (!have_cur) begin
            if (exp_q.size() == 0) begin
              n_cmp++;
              n_fail++;
              $display("FAIL unexpected_result: got sum %h with no pending operation", sum);
            end else begin
              cur = exp_q.pop_front();
              have_cur = 1;
              chk("sum", sum, cur.sum);
              chk("cout", W'(cout), W'(cur.cout));
              chk("ovf", W'(ovf), W'(cur.ovf));
              chk("latency", W'(ncyc - cur.acc), W'(NW + 1));
            end
          end else begin
            chk("sum_hold", sum, cur.sum);
            chk("cout_hold", W'(cout), W'(cur.cout));
            chk("ovf_hold", W'(ovf), W'(cur.ovf));
          end
          if (out_ready) have_cur = 0;
        end
        if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub, ncyc));
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob,
                       input logic oc, input logic os);
    int k;
    a = oa; b = ob; cin = oc; sub = os; in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 500) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 500) begin
      n_cmp++; n_fail++;
      $display("FAIL accept_timeout: got in_ready %0b want 1", in_ready);
    end else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int k;
    k = 0;
    while (!out_valid && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 100) begin
      n_cmp++; n_fail++;
      $display("FAIL valid_timeout: got out_valid %0b want 1", out_valid);
    end
  endtask

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] v;
    for (int i = 0; i < NW; i++) v[i*16 +: 16] = 16'($urandom);
    case ($urandom_range(0, 7))
      0: v = '1;
      1: v = '0;
      2: v = {1'b1, {(W-1){1'b0}}};
      3: v = {1'b0, {(W-1){1'b1}}};
      default: ;
    endcase
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_sum", sum, '0);
    chk("rst_cout", W'(cout), W'(0));
    chk("rst_ovf", W'(ovf), W'(0));
    @(posedge clk); #1;

    ready_mode = 2;
    do_op('1, W'(1), 1'b0, 1'b0);
    do_op({1'b0, {(W-1){1'b1}}}, '0, 1'b1, 1'b0);
    do_op(W'(5), W'(7), 1'b0, 1'b1);
    do_op(W'(7), W'(5), 1'b0, 1'b1);

    // Hold the result in DONE while new operands are already offered.
    wait_valid();
    @(posedge clk); #1;
    ready_mode = 1;
    do_op(W'(64'h1234_5678_9abc_def0), W'(64'h0fed_cba9_8765_4321), 1'b1, 1'b0);
    wait_valid();
    a = W'(64'h8000_0000_0000_0001); b = '1; cin = 1'b0; sub = 1'b1; in_valid = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
    end
    ready_mode = 2;
    do_op(W'(64'h8000_0000_0000_0001), '1, 1'b0, 1'b1);

    // Abort an operation halfway through with reset.
    wait_valid();
    @(posedge clk); #1;
    do_op('1, '1, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", W'(out_valid), W'(0));
    chk("abort_in_ready", W'(in_ready), W'(1));
    chk("abort_sum", sum, '0);
    @(posedge clk); #1;
    do_op(W'(1), W'(1), 1'b0, 1'b0);

    // Randomized traffic with random gaps and back-pressure.
    ready_mode = 0;
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      do_op(rand_w(), rand_w(), 1'($urandom), 1'($urandom));
    end

    ready_mode = 2;
    begin
      int k;
      k = 0;
      while ((exp_q.size() != 0 || out_valid || !in_ready) && k < 200) begin
        @(posedge clk); #1;
        k++;
      end
      if (k >= 200) begin
        n_cmp++; n_fail++;
        $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
      end
    end
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/wide_add_seq.md
Name: wide_add_seq

Overview:
Multi-cycle wide adder/subtractor built around the existing 16-bit ripple-carry stage `adder_16bit`. It latches a NUM_WORDS×16-bit operand pair through a valid/ready handshake. It feeds one 16-bit slice per cycle into its single `adder_16bit` instance, least-significant slice first, and chains the carry through a register. It presents the full-width sum, carry-out and signed overflow through an output valid/ready handshake. It sits directly upstream of `adder_16bit`, sequencing its operands and consuming its `y` and `Co`.

Parameters:
NUM_WORDS, 4, number of 16-bit slices; operand width W = 16*NUM_WORDS; legal range 1..16.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous reset, active-high.
in_valid  input  1  operand pair is offered.
in_ready  output  1  block can accept operands; high only in IDLE.
a  input  W  operand A.
b  input  W  operand B.
cin  input  1  carry-in for add; ignored for subtract.
sub  input  1  0 = a+b+cin; 1 = a-b (a + ~b + 1).
out_valid  output  1  result is valid; high only in DONE.
out_ready  input  1  consumer accepts the result.
sum  output  W  result; stable while out_valid=1.
cout  output  1  carry out of the MSB; for subtract, 1 means no borrow.
ovf  output  1  two's-complement overflow = a_msb' ^ b_msb' ^ sum_msb ^ cout, where b' is b after inversion when subtracting.

Behaviour:
- Reset values:
  - State IDLE; in_ready=1; out_valid=0.
  - sum=0, cout=0, ovf=0.
  - Slice index=0; carry register=0.
  - Reset overrides every other event, including mid-RUN and in DONE. Any partial result is discarded and never emitted.
- IDLE, on in_valid=1 at the rising edge:
  - Latch a into op_a.
  - Latch op_b = sub ? ~b : b.
  - Set carry register to sub ? 1 : cin.
  - Set index=0; go to RUN.
  - Input ports are not used again until the next IDLE.
- RUN, each cycle:
  - The adder_16bit instance receives op_a[16*idx +: 16], op_b[16*idx +: 16] and Cin=carry register.
  - On the edge: sum[16*idx +: 16] <= y; carry <= Co; idx <= idx+1.
  - When idx = NUM_WORDS-1: cout <= Co, ovf computed from the final values, go to DONE.
- DONE:
  - out_valid=1; sum, cout and ovf are held stable.
  - in_valid is ignored (in_ready=0).
  - On out_ready=1 at the edge, go to IDLE. sum, cout and ovf retain their last values until the next computation overwrites them.
- Latency: out_valid rises exactly NUM_WORDS cycles after the accepting edge. Throughput is one operation per NUM_WORDS+2 cycles minimum.
- The adder path is combinational within one cycle: a 16-bit ripple plus a mux.
- No other outputs toggle during RUN; sum is updated slice-by-slice internally but is qualified only by out_valid.
- Arithmetic: modulo 2^W, with no saturation.
- NUM_WORDS=1: RUN lasts one cycle.
- Index counter width is clog2(NUM_WORDS) bits, minimum 1. It never wraps in operation because it resets on accept.

Decomposition:
- Package wide_add_pkg:
  - State enum typedef {IDLE, RUN, DONE}.
  - Constant SLICE_W=16.
  - Function computing the index width.
- One sub-module: the existing adder_16bit, instantiated once. No new sub-modules.

Test Plan:
1. Assert rst for 2 cycles, then release -> in_ready=1, out_valid=0, sum=0, cout=0, ovf=0.
2. Add a=0xFFFF_FFFF_FFFF_FFFF, b=0x1, cin=0 -> sum=0x0, cout=1, ovf=0. out_valid is high exactly 4 cycles after the accepting edge.
3. Add a=0x7FFF_FFFF_FFFF_FFFF, b=0x0, cin=1 -> sum=0x8000_0000_0000_0000, cout=0, ovf=1.
4. Subtract a=0x5, b=0x7 -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0. Subtract a=0x7, b=0x5 -> sum=0x2, cout=1.
5. Hold out_ready=0 for 10 cycles in DONE while in_valid=1 with new operands -> sum, cout and ovf stay unchanged and in_ready=0. After out_ready=1: IDLE, then the new operands are accepted.
6. Assert rst for one cycle after 2 of 4 slices in RUN -> next cycle IDLE, out_valid=0, sum=0. The following add of 0x1+0x1 gives sum=0x2, with no stale carry.
